// File: rtl/gbuff_result_checker.sv
// Result scoreboard: streams the output gbuff and a golden buffer word by word, compares
// them lane by lane (optionally lane-reversed) and reports mismatch count and first error.
module gbuff_result_checker #(
  parameter int LANES         = 4,
  parameter int LANE_W        = 16,
  parameter int ADDR_W        = 8,
  parameter int DIM_W         = 4,
  parameter int REVERSE_LANES = 1,
  parameter int CNT_W         = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIM_W-1:0]          m,
  input  logic [DIM_W-1:0]          n,
  output logic                      out_rd_en,
  output logic [ADDR_W-1:0]         out_addr,
  input  logic [LANES*LANE_W-1:0]   out_rdata,
  output logic                      gold_rd_en,
  output logic [ADDR_W-1:0]         gold_addr,
  input  logic [LANES*LANE_W-1:0]   gold_rdata,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          err_cnt,
  output logic                      err_valid,
  output logic [ADDR_W-1:0]         first_err_addr,
  output logic [7:0]                first_err_lane
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t             state;
  logic [DIM_W-1:0]   m_q;
  logic [DIM_W-1:0]   wpr_q;
  logic [LANES-1:0]   last_mask_q;
  logic [DIM_W-1:0]   row_cnt;
  logic [DIM_W-1:0]   word_cnt;

  logic               p1_valid;
  logic               p1_last;
  logic [LANES-1:0]   p1_mask;
  logic [ADDR_W-1:0]  p1_addr;
  logic               last_upd;

  logic [DIM_W-1:0]   wpr_c;
  logic [LANES-1:0]   last_mask_c;
  logic               last_word_c;
  logic               is_last;
  logic [LANES-1:0]   cur_mask;
  logic [LANES-1:0]   mism;
  logic [CNT_W:0]     pop;
  logic [CNT_W:0]     sum;
  logic [CNT_W-1:0]   sat_cnt;
  logic [7:0]         first_lane_c;

  assign gold_rd_en = out_rd_en;
  assign gold_addr  = out_addr;

  // Words per row and the valid-lane mask of each row's last word, derived from n at start.
  always_comb begin : dims
    int n_i;
    int wpr_i;
    int vl_i;
    n_i   = int'(n);
    wpr_i = (n_i + LANES - 1) / LANES;
    vl_i  = n_i - (wpr_i - 1) * LANES;
    wpr_c = DIM_W'(wpr_i);
    last_mask_c = '0;
    for (int i = 0; i < LANES; i++) begin
      last_mask_c[i] = (i < vl_i);
    end
  end

  assign last_word_c = (word_cnt == wpr_q - 1'b1);
  assign is_last     = last_word_c && (row_cnt == m_q - 1'b1);
  assign cur_mask    = last_word_c ? last_mask_q : {LANES{1'b1}};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int G = (REVERSE_LANES != 0) ? (LANES - 1 - i) : i;
    assign mism[i] = p1_mask[i] &&
                     (out_rdata[i*LANE_W +: LANE_W] != gold_rdata[G*LANE_W +: LANE_W]);
  end

  // Lowest mismatching lane wins, so scan from the top down.
  always_comb begin
    pop          = '0;
    first_lane_c = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mism[i]) first_lane_c = 8'(i);
    end
    for (int i = 0; i < LANES; i++) begin
      pop = pop + {{CNT_W{1'b0}}, mism[i]};
    end
    sum     = {1'b0, err_cnt} + pop;
    sat_cnt = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      m_q            <= '0;
      wpr_q          <= '0;
      last_mask_q    <= '0;
      row_cnt        <= '0;
      word_cnt       <= '0;
      p1_valid       <= 1'b0;
      p1_last        <= 1'b0;
      p1_mask        <= '0;
      p1_addr        <= '0;
      last_upd       <= 1'b0;
      out_rd_en      <= 1'b0;
      out_addr       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_cnt        <= '0;
      err_valid      <= 1'b0;
      first_err_addr <= '0;
      first_err_lane <= '0;
    end else begin
      p1_valid <= out_rd_en;
      p1_addr  <= out_addr;
      p1_mask  <= cur_mask;
      p1_last  <= out_rd_en && is_last;
      last_upd <= p1_valid && p1_last;

      if (p1_valid) begin
        err_cnt <= sat_cnt;
        if ((|mism) && !err_valid) begin
          err_valid      <= 1'b1;
          first_err_addr <= p1_addr;
          first_err_lane <= first_lane_c;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            m_q            <= m;
            wpr_q          <= wpr_c;
            last_mask_q    <= last_mask_c;
            row_cnt        <= '0;
            word_cnt       <= '0;
            out_addr       <= '0;
            err_cnt        <= '0;
            err_valid      <= 1'b0;
            first_err_addr <= '0;
            first_err_lane <= '0;
            if (m == '0 || n == '0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy      <= 1'b1;
              done      <= 1'b0;
              out_rd_en <= 1'b1;
              state     <= READ;
            end
          end
        end
        READ: begin
          if (is_last) begin
            out_rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            out_addr <= out_addr + 1'b1;
            if (last_word_c) begin
              word_cnt <= '0;
              row_cnt  <= row_cnt + 1'b1;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (last_upd) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gbuff_result_checker.sv
// Bench for gbuff_result_checker: a lane-reversing and a straight instance share stimulus;
// addresses and end-of-pass results are checked against scoreboard queues fed by a model.
module tb_gbuff_result_checker;

  localparam int LANES  = 4;
  localparam int LANE_W = 16;
  localparam int ADDR_W = 8;
  localparam int DIM_W  = 4;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [CNT_W-1:0]  cnt;
    logic              valid;
    logic [ADDR_W-1:0] faddr;
    logic [7:0]        flane;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [DIM_W-1:0] m, n;

  logic rd0, grd0, busy0, done0, ev0;
  logic [ADDR_W-1:0] addr0, gaddr0, fa0;
  logic [7:0] fl0;
  logic [CNT_W-1:0] cnt0;
  logic [63:0] ordata0, grdata0;

  logic rd1, grd1, busy1, done1, ev1;
  logic [ADDR_W-1:0] addr1, gaddr1, fa1;
  logic [7:0] fl1;
  logic [CNT_W-1:0] cnt1;
  logic [63:0] ordata1, grdata1;

  logic [63:0] out_mem  [256];
  logic [63:0] gold_mem [256];

  int errors = 0;
  int checks = 0;
  int   exp_addr_q[$];
  res_t exp_q[$];
  res_t exp1_q[$];

  gbuff_result_checker #(.REVERSE_LANES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .m(m), .n(n),
    .out_rd_en(rd0), .out_addr(addr0), .out_rdata(ordata0),
    .gold_rd_en(grd0), .gold_addr(gaddr0), .gold_rdata(grdata0),
    .busy(busy0), .done(done0), .err_cnt(cnt0), .err_valid(ev0),
    .first_err_addr(fa0), .first_err_lane(fl0)
  );

  gbuff_result_checker #(.REVERSE_LANES(0)) dut_straight (
    .clk(clk), .rst(rst), .start(start), .m(m), .n(n),
    .out_rd_en(rd1), .out_addr(addr1), .out_rdata(ordata1),
    .gold_rd_en(grd1), .gold_addr(gaddr1), .gold_rdata(grdata1),
    .busy(busy1), .done(done1), .err_cnt(cnt1), .err_valid(ev1),
    .first_err_addr(fa1), .first_err_lane(fl1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd0)  ordata0 <= out_mem[addr0];
    if (grd0) grdata0 <= gold_mem[gaddr0];
    if (rd1)  ordata1 <= out_mem[addr1];
    if (grd1) grdata1 <= gold_mem[gaddr1];
  end

  // Read-address scoreboard: every issued read must match the next expected address.
  always @(negedge clk) begin : mon
    int e;
    if (rd0 === 1'b1) begin
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL rd_addr: read at addr %0d, required no read", addr0);
      end else begin
        e = exp_addr_q.pop_front();
        if (addr0 !== 8'(e)) begin
          errors++;
          $display("[TB] FAIL rd_addr: got %0d required %0d", addr0, e);
        end
      end
    end
    if (rd0 === 1'b1 || grd0 === 1'b1) begin
      checks++;
      if (grd0 !== rd0 || gaddr0 !== addr0) begin
        errors++;
        $display("[TB] FAIL gold_mirror: gold_rd_en=%b gold_addr=%0d required %b/%0d",
                 grd0, gaddr0, rd0, addr0);
      end
    end
  end

  function automatic logic [63:0] rev_word(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < LANES; i++) r[i*LANE_W +: LANE_W] = w[(LANES-1-i)*LANE_W +: LANE_W];
    return r;
  endfunction

  // Reference model: walks the result matrix element by element.
  function automatic res_t model(input int mm, input int nn, input bit rev);
    res_t r;
    int wpr, a, lane, gl;
    r = '0;
    wpr = (nn + LANES - 1) / LANES;
    for (int rr = 0; rr < mm; rr++) begin
      for (int c = 0; c < nn; c++) begin
        a    = rr * wpr + c / LANES;
        lane = c % LANES;
        gl   = rev ? (LANES - 1 - lane) : lane;
        if (out_mem[a][lane*LANE_W +: LANE_W] !== gold_mem[a][gl*LANE_W +: LANE_W]) begin
          if (!r.valid) begin
            r.valid = 1'b1;
            r.faddr = 8'(a);
            r.flane = 8'(lane);
          end
          r.cnt = r.cnt + 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic fill_match(input int words);
    for (int a = 0; a < words; a++) begin
      gold_mem[a] = {$urandom, $urandom};
      out_mem[a]  = rev_word(gold_mem[a]);
    end
  endtask

  task automatic push_addrs(input int words);
    for (int a = 0; a < words; a++) exp_addr_q.push_back(a);
  endtask

  // Pulses start and counts cycles until done; optional extra start pulse mid-pass.
  task automatic start_pass(input int mm, input int nn, input int restart_at, output int dc);
    @(negedge clk);
    m = 4'(mm); n = 4'(nn); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dc = 1;
    while (done0 !== 1'b1 && dc < 300) begin
      start = (dc == restart_at);
      if (start) begin m = 4'd1; n = 4'd1; end
      @(negedge clk);
      dc++;
    end
    start = 1'b0;
    if (done0 !== 1'b1) dc = -1;
  endtask

  task automatic test_reset;
    checks++;
    if ({busy0, done0, rd0, grd0, addr0, gaddr0, cnt0, ev0, fa0, fl0} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: busy=%b done=%b rd=%b addr=%0d cnt=%0d ev=%b fa=%0d fl=%0d required all 0",
               busy0, done0, rd0, addr0, cnt0, ev0, fa0, fl0);
    end
  endtask

  task automatic test_match;
    int dc;
    res_t e;
    fill_match(4);
    push_addrs(4);
    exp_q.push_back('0);
    start_pass(4, 4, 0, dc);
    checks++;
    if (dc !== 7) begin errors++; $display("[TB] FAIL match_done_cycle: got %0d required 7", dc); end
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++; $display("[TB] FAIL match_reads: %0d reads missing, required 0", exp_addr_q.size());
    end
    e = exp_q.pop_front();
    checks++;
    if (cnt0 !== e.cnt || ev0 !== e.valid) begin
      errors++; $display("[TB] FAIL match_result: cnt=%0d ev=%b required %0d/%b", cnt0, ev0, e.cnt, e.valid);
    end
  endtask

  task automatic test_masking;
    int dc;
    res_t e;
    fill_match(4);
    out_mem[1][63:32] = ~out_mem[1][63:32];
    out_mem[3][63:32] = ~out_mem[3][63:32];
    push_addrs(4);
    exp_q.push_back('0);
    start_pass(2, 6, 0, dc);
    checks++;
    if (dc !== 7) begin errors++; $display("[TB] FAIL mask_done_cycle: got %0d required 7", dc); end
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++; $display("[TB] FAIL mask_reads: %0d reads missing, required 0", exp_addr_q.size());
    end
    e = exp_q.pop_front();
    checks++;
    if (cnt0 !== e.cnt || ev0 !== e.valid) begin
      errors++; $display("[TB] FAIL mask_result: cnt=%0d ev=%b required %0d/%b", cnt0, ev0, e.cnt, e.valid);
    end
  endtask

  task automatic test_mismatch;
    int dc;
    res_t e;
    fill_match(4);
    out_mem[2][31:16] = ~out_mem[2][31:16];
    out_mem[3][63:48] = ~out_mem[3][63:48];
    push_addrs(4);
    exp_q.push_back('{cnt: 16'd2, valid: 1'b1, faddr: 8'd2, flane: 8'd1});
    start_pass(4, 4, 0, dc);
    checks++;
    if (dc !== 7) begin errors++; $display("[TB] FAIL mism_done_cycle: got %0d required 7", dc); end
    e = exp_q.pop_front();
    checks++;
    if (cnt0 !== e.cnt || ev0 !== e.valid) begin
      errors++; $display("[TB] FAIL mism_count: cnt=%0d ev=%b required %0d/%b", cnt0, ev0, e.cnt, e.valid);
    end
    checks++;
    if (fa0 !== e.faddr || fl0 !== e.flane) begin
      errors++; $display("[TB] FAIL mism_first: addr=%0d lane=%0d required %0d/%0d", fa0, fl0, e.faddr, e.flane);
    end
  endtask

  task automatic test_empty;
    int dc;
    int mm [2] = '{0, 3};
    int nn [2] = '{5, 0};
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('0);
      start_pass(mm[k], nn[k], 0, dc);
      checks++;
      if (dc !== 1 || busy0 !== 1'b0) begin
        errors++; $display("[TB] FAIL empty_done: cycle=%0d busy=%b required 1/0", dc, busy0);
      end
      checks++;
      if (cnt0 !== exp_q[0].cnt || ev0 !== exp_q[0].valid) begin
        errors++; $display("[TB] FAIL empty_result: cnt=%0d ev=%b required 0/0", cnt0, ev0);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reverse;
    int dc;
    res_t e;
    gold_mem[0] = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    out_mem[0]  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    push_addrs(1);
    exp_q.push_back('0);
    exp1_q.push_back('{cnt: 16'd4, valid: 1'b1, faddr: 8'd0, flane: 8'd0});
    start_pass(1, 4, 0, dc);
    checks++;
    if (dc !== 4) begin errors++; $display("[TB] FAIL rev_done_cycle: got %0d required 4", dc); end
    e = exp_q.pop_front();
    checks++;
    if (cnt0 !== e.cnt || ev0 !== e.valid) begin
      errors++; $display("[TB] FAIL rev_reversed: cnt=%0d ev=%b required %0d/%b", cnt0, ev0, e.cnt, e.valid);
    end
    e = exp1_q.pop_front();
    checks++;
    if ({cnt1, ev1, fa1, fl1} !== e) begin
      errors++; $display("[TB] FAIL rev_straight: cnt=%0d ev=%b fa=%0d fl=%0d required %0d/%b/%0d/%0d",
                         cnt1, ev1, fa1, fl1, e.cnt, e.valid, e.faddr, e.flane);
    end
  endtask

  task automatic test_back_to_back;
    int dc, mm, nn, w;
    res_t e;
    for (int it = 0; it < 5; it++) begin
      mm = $urandom_range(1, 15);
      nn = $urandom_range(1, 15);
      w  = mm * ((nn + LANES - 1) / LANES);
      fill_match(w);
      for (int a = 0; a < w; a++)
        for (int l = 0; l < LANES; l++)
          if ($urandom_range(0, 7) == 0)
            out_mem[a][l*LANE_W +: LANE_W] = out_mem[a][l*LANE_W +: LANE_W] ^ 16'($urandom_range(1, 65535));
      push_addrs(w);
      exp_q.push_back(model(mm, nn, 1'b1));
      exp1_q.push_back(model(mm, nn, 1'b0));
      start_pass(mm, nn, 0, dc);
      checks++;
      if (dc !== w + 3) begin
        errors++; $display("[TB] FAIL b2b_done_cycle: m=%0d n=%0d got %0d required %0d", mm, nn, dc, w + 3);
      end
      e = exp_q.pop_front();
      checks++;
      if ({cnt0, ev0, fa0, fl0} !== e) begin
        errors++; $display("[TB] FAIL b2b_reversed: cnt=%0d ev=%b fa=%0d fl=%0d required %0d/%b/%0d/%0d",
                           cnt0, ev0, fa0, fl0, e.cnt, e.valid, e.faddr, e.flane);
      end
      e = exp1_q.pop_front();
      checks++;
      if ({cnt1, ev1, fa1, fl1} !== e) begin
        errors++; $display("[TB] FAIL b2b_straight: cnt=%0d ev=%b fa=%0d fl=%0d required %0d/%b/%0d/%0d",
                           cnt1, ev1, fa1, fl1, e.cnt, e.valid, e.faddr, e.flane);
      end
    end
  endtask

  task automatic test_mid_reset;
    int dc;
    res_t e;
    fill_match(8);
    out_mem[0][15:0] = ~out_mem[0][15:0];
    push_addrs(8);
    @(negedge clk);
    m = 4'd4; n = 4'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cnt0 !== 16'd1) begin errors++; $display("[TB] FAIL pre_reset_cnt: got %0d required 1", cnt0); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy0, done0, rd0, addr0, cnt0, ev0, fa0, fl0} !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_clear: busy=%b done=%b rd=%b addr=%0d cnt=%0d ev=%b required all 0",
               busy0, done0, rd0, addr0, cnt0, ev0);
    end
    checks++;
    if (exp_addr_q.size() != 5) begin
      errors++; $display("[TB] FAIL mid_reset_reads: %0d pending, required 5", exp_addr_q.size());
    end
    @(negedge clk);
    rst = 1'b0;
    exp_addr_q.delete();
    out_mem[0] = rev_word(gold_mem[0]);
    push_addrs(8);
    exp_q.push_back('0);
    start_pass(4, 8, 4, dc);
    checks++;
    if (dc !== 11) begin errors++; $display("[TB] FAIL restart_done_cycle: got %0d required 11", dc); end
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++; $display("[TB] FAIL restart_reads: %0d reads missing, required 0", exp_addr_q.size());
    end
    e = exp_q.pop_front();
    checks++;
    if (cnt0 !== e.cnt || ev0 !== e.valid) begin
      errors++; $display("[TB] FAIL restart_result: cnt=%0d ev=%b required %0d/%b", cnt0, ev0, e.cnt, e.valid);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) begin
      out_mem[a]  = '0;
      gold_mem[a] = '0;
    end
    rst = 1'b1; start = 1'b0; m = '0; n = '0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    test_match;
    test_masking;
    test_mismatch;
    test_empty;
    test_reverse;
    test_back_to_back;
    test_mid_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gbuff_result_checker.md
Name: gbuff_result_checker

Overview:
- Synthesizable self-checking result scoreboard for the TPU output path.
- Streams the output global buffer and a golden buffer word by word, compares them lane by lane with a configurable lane order, and masks the unused lanes in each row's last word.
- Reports the mismatch count and the first failing location.
- Replaces the ad-hoc per-lane compare loops in simulation, and is reusable on FPGA/emulation builds.

Parameters:
LANES, 4, number of result lanes per buffer word
LANE_W, 16, bits per lane
ADDR_W, 8, buffer address width
DIM_W, 4, width of the m/n dimension inputs
REVERSE_LANES, 1, 1: output lane i is compared with golden lane LANES-1-i; 0: lane i with lane i
CNT_W, 16, error counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  begin a check pass; sampled only in IDLE or DONE
m  in  DIM_W  result rows (matrix A rows)
n  in  DIM_W  result columns (matrix B cols)
out_rd_en  out  1  read strobe to the output gbuff
out_addr  out  ADDR_W  output gbuff read address
out_rdata  in  LANES*LANE_W  output gbuff data, valid 1 cycle after out_rd_en
gold_rd_en  out  1  read strobe to the golden buffer (identical to out_rd_en)
gold_addr  out  ADDR_W  golden read address (identical to out_addr)
gold_rdata  in  LANES*LANE_W  golden data, valid 1 cycle after gold_rd_en
busy  out  1  pass in progress
done  out  1  level; pass complete, held until the next start or reset
err_cnt  out  CNT_W  number of mismatching lanes, saturating
err_valid  out  1  at least one mismatch in this pass
first_err_addr  out  ADDR_W  word address of the first mismatch
first_err_lane  out  8  output-side lane index of the first mismatch

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. Reset acts immediately, including in the middle of a pass; any partial results are discarded.
- Words per row: wpr = ceil(n/LANES). Total words: W = m*wpr. Addresses run linearly from 0 to W-1.
- Iteration uses row and word counters; no multiplier is needed.
- FSM states:
  - IDLE: on start, go to READ. Latch m and n, clear err_cnt/err_valid/first_err_*, assert busy, deassert done.
  - READ: assert rd_en for W consecutive cycles. out_addr starts at 0 and increments by 1 each cycle. After the last issue, go to DRAIN.
  - DRAIN: wait for the last word's compare to update the counters, then go to DONE.
  - DONE: done=1, busy=0, results held. On start, go to READ exactly as from IDLE.
- m==0 or n==0: skip READ. No rd_en is issued. done=1 the cycle after start, with err_cnt=0.
- Pipeline, at one word per cycle:
  - cycle t: issue address.
  - cycle t+1: rdata valid; the lane-valid mask and address are delayed to align with it.
  - edge ending t+1: compare result registered into err_cnt and first_err_*.
  - done rises the cycle after the final update.
- Latency: for W>0, done is 1 in cycle W+3, counting the cycle after the start edge as cycle 1.
- Lane masking: in a row's last word, only the first vl = n-(wpr-1)*LANES output lanes are compared; the remaining lanes are ignored. All other words compare every lane.
- Compare: output lane i is bits [i*LANE_W +: LANE_W]. Its golden partner is lane LANES-1-i when REVERSE_LANES=1, else lane i. Equality is bitwise.
- err_cnt adds the popcount of mismatching valid lanes each word, and saturates at all-ones.
- First error: captured on the first word that has any mismatch. If several lanes mismatch in that word, the lowest output lane index wins. Later errors never overwrite it.
- start while busy is ignored.
- The m and n inputs are ignored after latching; changes mid-pass have no effect.

Test Plan:
1. LANES=4, m=4, n=4, out == golden (reverse-mapped) -> addresses 0..3 read on 4 consecutive cycles; done in cycle 7; err_cnt=0; err_valid=0.
2. m=2, n=6, lanes 2-3 of addresses 1 and 3 filled with garbage, all else matching -> 4 reads; err_cnt=0 (masking works).
3. Mismatch injected at addr 2 out lane 1 and addr 3 out lane 3 -> err_cnt=2, err_valid=1, first_err_addr=2, first_err_lane=1.
4. Golden word {0x1111,0x2222,0x3333,0x4444} with out holding the reversed lane order -> REVERSE_LANES=1 gives err_cnt=0; REVERSE_LANES=0 build gives err_cnt=4.
5. m=0, n=5, start -> no rd_en ever asserted; done=1 the next cycle; err_cnt=0.
6. rst pulsed after 3 reads of an m=4, n=8 pass -> all outputs 0 asynchronously and FSM in IDLE. A new start runs 8 reads with correct results. A start pulse during that busy pass is ignored, with no restart and address sequence unchanged.
